// File: rtl/veda_mem_pkg.sv
// rtl/veda_mem_pkg.sv - shared types and constants for the VEDA memory arbiter
// Purpose: state encoding, requester ids, memory mode values, default sizes
// and the address range check used by the arbiter.
package veda_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam logic MODE_READ  = 1'b1;
  localparam logic MODE_WRITE = 1'b0;

  localparam int DEFAULT_DEPTH  = 256;
  localparam int DEFAULT_DATA_W = 32;

  // Full 32-bit compare: high address bits never wrap into the array.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction

endpackage

// File: rtl/veda_mem_arbiter_if.sv
// rtl/veda_mem_arbiter_if.sv - request/response and memory-side bus bundle
// Purpose: groups the IFU port, the LSU port, the memory control port and busy.
// Modports:
//   slave  - arbiter side: takes requests and mem_rdata, drives grants,
//            responses, memory controls and busy.
//   master - core/memory side: the mirror image of slave.
interface veda_mem_arbiter_if #(
  parameter int DATA_W = 32
);

  logic              ifu_req;
  logic [31:0]       ifu_addr;
  logic              ifu_gnt;
  logic              ifu_rvalid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_err;

  logic              lsu_req;
  logic              lsu_we;
  logic [31:0]       lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic              lsu_gnt;
  logic              lsu_rvalid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_err;

  logic [31:0]       mem_addr;
  logic              mem_mode;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
    input  mem_rdata,
    output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    output mem_addr, mem_mode, mem_write_en, mem_write_data,
    output busy
  );

  modport master (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata,
    output mem_rdata,
    input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    input  mem_addr, mem_mode, mem_write_en, mem_write_data,
    input  busy
  );

endinterface

// File: rtl/veda_rr_arb2.sv
// rtl/veda_rr_arb2.sv - two-requester round-robin arbiter
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en_i      - grants allowed this cycle
//   req_i[1:0]- requests, bit 0 = IFU, bit 1 = LSU
//   gnt_o[1:0]- one-hot grant (combinational), same bit order
module veda_rr_arb2
  import veda_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;
  logic [1:0] gnt;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        // Tie goes to whichever port was not served last.
        gnt = (last_q == REQ_IFU) ? 2'b10 : 2'b01;
      end else begin
        gnt = req_i;
      end
      if (gnt[0]) begin
        last_d = REQ_IFU;
      end else if (gnt[1]) begin
        last_d = REQ_LSU;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_LSU;
    end else begin
      last_q <= last_d;
    end
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/veda_mem_arbiter.sv
// rtl/veda_mem_arbiter.sv - IFU/LSU arbiter and sequencer for the VEDA data memory
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave modport: IFU/LSU request+response, memory controls, busy
// Grant in cycle N, memory access at the edge ending N+1, rvalid in N+2.
module veda_mem_arbiter
  import veda_mem_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  veda_mem_arbiter_if.slave  bus
);

  state_e            state_q;
  logic              id_q;
  logic              err_q;
  logic              mem_mode_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              gnt_en;
  logic [1:0]        gnt_vec;
  logic              any_gnt;
  logic              gnt_id;
  logic [31:0]       addr_d;
  logic              we_d;
  logic              err_d;
  logic [DATA_W-1:0] wdata_d;

  assign gnt_en = (state_q == ST_IDLE) || (state_q == ST_RESP);

  veda_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (gnt_en),
    .req_i ({bus.lsu_req, bus.ifu_req}),
    .gnt_o (gnt_vec)
  );

  assign any_gnt = |gnt_vec;
  assign gnt_id  = gnt_vec[1] ? REQ_LSU : REQ_IFU;
  assign addr_d  = (gnt_id == REQ_LSU) ? bus.lsu_addr : bus.ifu_addr;
  assign we_d    = (gnt_id == REQ_LSU) && bus.lsu_we;
  assign wdata_d = bus.lsu_wdata;
  assign err_d   = !addr_in_range(addr_d, DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      id_q        <= REQ_IFU;
      err_q       <= 1'b0;
      mem_mode_q  <= MODE_WRITE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (any_gnt) begin
            state_q    <= ST_ISSUE;
            id_q       <= gnt_id;
            err_q      <= err_d;
            mem_mode_q <= (!err_d && !we_d) ? MODE_READ : MODE_WRITE;
            mem_we_q   <= !err_d && we_d;
            // Out-of-range accesses leave address/data untouched so the
            // memory sees a pure no-op.
            if (!err_d) begin
              mem_addr_q <= addr_d;
            end
            if (!err_d && we_d) begin
              mem_wdata_q <= wdata_d;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_q    <= ST_RESP;
          mem_mode_q <= MODE_WRITE;
          mem_we_q   <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          mem_mode_q <= MODE_WRITE;
          mem_we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ifu_gnt = gnt_vec[0];
  assign bus.lsu_gnt = gnt_vec[1];

  // Responses are decoded from RESP; rdata comes straight from the memory
  // output register, which holds the read word or the echoed write word.
  assign bus.ifu_rvalid = (state_q == ST_RESP) && (id_q == REQ_IFU);
  assign bus.lsu_rvalid = (state_q == ST_RESP) && (id_q == REQ_LSU);
  assign bus.ifu_err    = bus.ifu_rvalid && err_q;
  assign bus.lsu_err    = bus.lsu_rvalid && err_q;
  assign bus.ifu_rdata  = (bus.ifu_rvalid && !err_q) ? bus.mem_rdata : '0;
  assign bus.lsu_rdata  = (bus.lsu_rvalid && !err_q) ? bus.mem_rdata : '0;

  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_mode       = mem_mode_q;
  assign bus.mem_write_en   = mem_we_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_veda_mem_arbiter.sv
// tb/tb_veda_mem_arbiter.sv - directed self-checking bench for veda_mem_arbiter
module tb_veda_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  veda_mem_arbiter_if #(.DATA_W(32)) bus ();

  veda_mem_arbiter #(.DEPTH(256), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural VEDA_memory: registered output, echoes written word.
  logic [31:0] mem [0:255];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 256; k++) mem[k] = 32'h0;
      mem[5]     = 32'hDEADBEEF;
      mem[44]    = 32'h44444444;
      mem_loaded = 1'b1;
    end
    if (bus.mem_write_en) begin
      mem[bus.mem_addr[7:0]] = bus.mem_write_data;
      bus.mem_rdata <= bus.mem_write_data;
    end else if (bus.mem_mode) begin
      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", bus.busy); end
    total++; if (bus.ifu_gnt !== 1'b0 || bus.lsu_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0b%0b want=00", bus.ifu_gnt, bus.lsu_gnt); end
    total++; if (bus.ifu_rvalid !== 1'b0 || bus.lsu_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b%0b want=00", bus.ifu_rvalid, bus.lsu_rvalid); end
    total++; if (bus.ifu_err !== 1'b0 || bus.lsu_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b%0b want=00", bus.ifu_err, bus.lsu_err); end
    total++; if (bus.mem_mode !== 1'b0 || bus.mem_write_en !== 1'b0) begin bad++; $display("FAIL rst_memctl got=%0b%0b want=00", bus.mem_mode, bus.mem_write_en); end
    total++; if (bus.mem_addr !== 32'h0 || bus.mem_write_data !== 32'h0) begin bad++; $display("FAIL rst_memaddr got=%h/%h want=0/0", bus.mem_addr, bus.mem_write_data); end
    total++; if (bus.ifu_rdata !== 32'h0 || bus.lsu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h want=0/0", bus.ifu_rdata, bus.lsu_rdata); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ifu_read();
    tick(); bus.ifu_req = 1'b1; bus.ifu_addr = 32'd5; #1;
    total++; if (bus.ifu_gnt !== 1'b1 || bus.lsu_gnt !== 1'b0) begin bad++; $display("FAIL rd_gnt got=%0b%0b want=10", bus.ifu_gnt, bus.lsu_gnt); end
    tick(); bus.ifu_req = 1'b0; #1;
    total++; if (bus.mem_mode !== 1'b1 || bus.mem_write_en !== 1'b0) begin bad++; $display("FAIL rd_issue_ctl got=%0b%0b want=10", bus.mem_mode, bus.mem_write_en); end
    total++; if (bus.mem_addr !== 32'd5) begin bad++; $display("FAIL rd_issue_addr got=%0d want=5", bus.mem_addr); end
    total++; if (bus.busy !== 1'b1 || bus.ifu_rvalid !== 1'b0) begin bad++; $display("FAIL rd_issue_busy got=%0b/%0b want=1/0", bus.busy, bus.ifu_rvalid); end
    tick(); #1;
    total++; if (bus.ifu_rvalid !== 1'b1 || bus.lsu_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid got=%0b%0b want=10", bus.ifu_rvalid, bus.lsu_rvalid); end
    total++; if (bus.ifu_rdata !== 32'hDEADBEEF || bus.ifu_err !== 1'b0) begin bad++; $display("FAIL rd_data got=%h/%0b want=deadbeef/0", bus.ifu_rdata, bus.ifu_err); end
    tick(); #1;
    total++; if (bus.busy !== 1'b0 || bus.mem_mode !== 1'b0 || bus.mem_addr !== 32'd5) begin bad++; $display("FAIL rd_idle got=%0b/%0b/%0d want=0/0/5", bus.busy, bus.mem_mode, bus.mem_addr); end
  endtask

  task automatic test_write_read();
    tick(); bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'd10; bus.lsu_wdata = 32'h12345678; #1;
    total++; if (bus.lsu_gnt !== 1'b1 || bus.ifu_gnt !== 1'b0) begin bad++; $display("FAIL wr_gnt got=%0b%0b want=01", bus.ifu_gnt, bus.lsu_gnt); end
    tick(); bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; #1;
    total++; if (bus.mem_write_en !== 1'b1 || bus.mem_mode !== 1'b0) begin bad++; $display("FAIL wr_issue_ctl got=%0b%0b want=01", bus.mem_mode, bus.mem_write_en); end
    total++; if (bus.mem_addr !== 32'd10 || bus.mem_write_data !== 32'h12345678) begin bad++; $display("FAIL wr_issue_bus got=%0d/%h want=10/12345678", bus.mem_addr, bus.mem_write_data); end
    tick(); #1;
    total++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rdata !== 32'h12345678 || bus.ifu_rvalid !== 1'b0) begin bad++; $display("FAIL wr_resp got=%0b/%h/%0b want=1/12345678/0", bus.lsu_rvalid, bus.lsu_rdata, bus.ifu_rvalid); end
    total++; if (mem[10] !== 32'h12345678) begin bad++; $display("FAIL wr_mem got=%h want=12345678", mem[10]); end
    tick(); bus.ifu_req = 1'b1; bus.ifu_addr = 32'd10; #1;
    total++; if (bus.ifu_gnt !== 1'b1) begin bad++; $display("FAIL rb_gnt got=%0b want=1", bus.ifu_gnt); end
    tick(); bus.ifu_req = 1'b0;
    tick(); #1;
    total++; if (bus.ifu_rvalid !== 1'b1 || bus.ifu_rdata !== 32'h12345678) begin bad++; $display("FAIL rb_data got=%0b/%h want=1/12345678", bus.ifu_rvalid, bus.ifu_rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    logic e_ig, e_lg, e_iv, e_lv;
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (i == 0) begin
        bus.ifu_req = 1'b1; bus.ifu_addr = 32'd5;
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'd10;
      end
      if (i == 8) begin
        bus.ifu_req = 1'b0; bus.lsu_req = 1'b0;
      end
      #1;
      e_ig = (i % 4 == 0) && (i < 8);
      e_lg = (i % 4 == 2);
      e_iv = (i % 4 == 2);
      e_lv = (i % 4 == 0) && (i > 0);
      total++; if (bus.ifu_gnt !== e_ig || bus.lsu_gnt !== e_lg) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%0b%0b want=%0b%0b", i, bus.ifu_gnt, bus.lsu_gnt, e_ig, e_lg); end
      total++; if (bus.ifu_rvalid !== e_iv || bus.lsu_rvalid !== e_lv) begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%0b%0b want=%0b%0b", i, bus.ifu_rvalid, bus.lsu_rvalid, e_iv, e_lv); end
      if (e_iv) begin
        total++; if (bus.ifu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rr_ifu_data cyc=%0d got=%h want=deadbeef", i, bus.ifu_rdata); end
      end
      if (e_lv) begin
        total++; if (bus.lsu_rdata !== 32'h12345678) begin bad++; $display("FAIL rr_lsu_data cyc=%0d got=%h want=12345678", i, bus.lsu_rdata); end
      end
    end
    tick();
  endtask

  task automatic test_out_of_range();
    tick(); bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'd300; bus.lsu_wdata = 32'hAAAA5555; #1;
    total++; if (bus.lsu_gnt !== 1'b1) begin bad++; $display("FAIL oor_gnt got=%0b want=1", bus.lsu_gnt); end
    tick(); bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; #1;
    total++; if (bus.mem_write_en !== 1'b0 || bus.mem_mode !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL oor_issue got=we%0b mode%0b busy%0b want=we0 mode0 busy1", bus.mem_write_en, bus.mem_mode, bus.busy); end
    tick(); #1;
    total++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_err !== 1'b1 || bus.lsu_rdata !== 32'h0) begin bad++; $display("FAIL oor_resp got=%0b/%0b/%h want=1/1/0", bus.lsu_rvalid, bus.lsu_err, bus.lsu_rdata); end
    total++; if (bus.mem_write_en !== 1'b0) begin bad++; $display("FAIL oor_resp_we got=%0b want=0", bus.mem_write_en); end
    tick(); #1;
    total++; if (mem[44] !== 32'h44444444) begin bad++; $display("FAIL oor_mem44 got=%h want=44444444", mem[44]); end
    total++; if (bus.lsu_err !== 1'b0) begin bad++; $display("FAIL oor_err_clear got=%0b want=0", bus.lsu_err); end
  endtask

  task automatic test_reset_mid();
    tick(); bus.ifu_req = 1'b1; bus.ifu_addr = 32'd5; #1;
    total++; if (bus.ifu_gnt !== 1'b1) begin bad++; $display("FAIL rm_gnt got=%0b want=1", bus.ifu_gnt); end
    tick(); bus.ifu_req = 1'b0; #1;
    total++; if (bus.mem_mode !== 1'b1) begin bad++; $display("FAIL rm_issue got=%0b want=1", bus.mem_mode); end
    rst = 1'b1; #1;
    total++; if (bus.busy !== 1'b0 || bus.mem_mode !== 1'b0 || bus.mem_write_en !== 1'b0) begin bad++; $display("FAIL rm_ctl got=%0b/%0b/%0b want=0/0/0", bus.busy, bus.mem_mode, bus.mem_write_en); end
    total++; if (bus.mem_addr !== 32'h0 || bus.mem_write_data !== 32'h0) begin bad++; $display("FAIL rm_bus got=%h/%h want=0/0", bus.mem_addr, bus.mem_write_data); end
    total++; if (bus.ifu_rvalid !== 1'b0 || bus.ifu_rdata !== 32'h0) begin bad++; $display("FAIL rm_resp got=%0b/%h want=0/0", bus.ifu_rvalid, bus.ifu_rdata); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.ifu_rvalid !== 1'b0) begin bad++; $display("FAIL rm_norvalid cyc=%0d got=%0b want=0", i, bus.ifu_rvalid); end
    end
    @(negedge clk);
    rst = 1'b0;
    tick(); bus.ifu_req = 1'b1; bus.ifu_addr = 32'd5; bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'd10; #1;
    total++; if (bus.ifu_gnt !== 1'b1 || bus.lsu_gnt !== 1'b0) begin bad++; $display("FAIL rm_tie got=%0b%0b want=10", bus.ifu_gnt, bus.lsu_gnt); end
    tick(); bus.ifu_req = 1'b0; bus.lsu_req = 1'b0;
    tick(); #1;
    total++; if (bus.ifu_rvalid !== 1'b1 || bus.ifu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rm_after got=%0b/%h want=1/deadbeef", bus.ifu_rvalid, bus.ifu_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    tick(); bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'd20; bus.lsu_wdata = 32'hA1A1A1A1; #1;
    total++; if (bus.lsu_gnt !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_c0 got=%0b/%0b want=1/0", bus.lsu_gnt, bus.busy); end
    tick(); #1;
    total++; if (bus.busy !== 1'b1 || bus.lsu_gnt !== 1'b0 || bus.mem_write_en !== 1'b1 || bus.mem_addr !== 32'd20) begin bad++; $display("FAIL b2b_c1 got=%0b/%0b/%0b/%0d want=1/0/1/20", bus.busy, bus.lsu_gnt, bus.mem_write_en, bus.mem_addr); end
    tick(); bus.lsu_addr = 32'd21; bus.lsu_wdata = 32'hB2B2B2B2; #1;
    total++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_gnt !== 1'b1 || bus.busy !== 1'b1 || bus.lsu_rdata !== 32'hA1A1A1A1) begin bad++; $display("FAIL b2b_c2 got=%0b/%0b/%0b/%h want=1/1/1/a1a1a1a1", bus.lsu_rvalid, bus.lsu_gnt, bus.busy, bus.lsu_rdata); end
    tick(); #1;
    total++; if (bus.busy !== 1'b1 || bus.mem_write_en !== 1'b1 || bus.mem_addr !== 32'd21) begin bad++; $display("FAIL b2b_c3 got=%0b/%0b/%0d want=1/1/21", bus.busy, bus.mem_write_en, bus.mem_addr); end
    tick(); bus.lsu_we = 1'b0; bus.lsu_addr = 32'd20; #1;
    total++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_gnt !== 1'b1 || bus.busy !== 1'b1 || bus.lsu_rdata !== 32'hB2B2B2B2) begin bad++; $display("FAIL b2b_c4 got=%0b/%0b/%0b/%h want=1/1/1/b2b2b2b2", bus.lsu_rvalid, bus.lsu_gnt, bus.busy, bus.lsu_rdata); end
    tick(); bus.lsu_req = 1'b0; #1;
    total++; if (bus.busy !== 1'b1 || bus.mem_mode !== 1'b1 || bus.mem_addr !== 32'd20) begin bad++; $display("FAIL b2b_c5 got=%0b/%0b/%0d want=1/1/20", bus.busy, bus.mem_mode, bus.mem_addr); end
    tick(); #1;
    total++; if (bus.lsu_rvalid !== 1'b1 || bus.lsu_gnt !== 1'b0 || bus.busy !== 1'b1 || bus.lsu_rdata !== 32'hA1A1A1A1) begin bad++; $display("FAIL b2b_c6 got=%0b/%0b/%0b/%h want=1/0/1/a1a1a1a1", bus.lsu_rvalid, bus.lsu_gnt, bus.busy, bus.lsu_rdata); end
    tick(); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_c7 got=%0b want=0", bus.busy); end
  endtask

  initial begin
    bus.ifu_req   = 1'b0;
    bus.ifu_addr  = 32'h0;
    bus.lsu_req   = 1'b0;
    bus.lsu_we    = 1'b0;
    bus.lsu_addr  = 32'h0;
    bus.lsu_wdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_ifu_read();
    test_write_read();
    test_round_robin();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/veda_mem_arbiter.md
# veda_mem_arbiter

Two-port arbiter and sequencer for the 256×32 VEDA data memory. It shares the single memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It grants requests round-robin and drives the memory's mode/write-enable/address/data controls. It returns the memory's registered read data, or the write-back data, to the granted requester with a valid strobe. It sits between the core's IFU/LSU and `VEDA_memory`.

## Interface
- `DEPTH`, 256: memory words; addresses ≥ DEPTH are out of range.
- `DATA_W`, 32: data width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ifu_req` in 1: IFU read request; held until `ifu_gnt`.
- `ifu_addr` in 32: IFU word address.
- `ifu_gnt` out 1: request accepted this cycle (combinational).
- `ifu_rvalid` out 1: one-cycle response strobe.
- `ifu_rdata` out DATA_W: read data, valid with `ifu_rvalid`.
- `ifu_err` out 1: out-of-range flag, valid with `ifu_rvalid`.
- `lsu_req`, `lsu_we`, `lsu_addr[31:0]`, `lsu_wdata[DATA_W-1:0]` in: LSU request (`lsu_we`=1 write).
- `lsu_gnt`, `lsu_rvalid`, `lsu_rdata[DATA_W-1:0]`, `lsu_err` out: same meaning as the IFU outputs.
- `mem_addr` out 32: memory address.
- `mem_mode` out 1: 1 = read, 0 = write/no-op.
- `mem_write_en` out 1: memory write enable.
- `mem_write_data` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory registered output.
- `busy` out 1: high in ISSUE or RESP.

## Operation
- FSM states:
  - IDLE→ISSUE on any grant.
  - ISSUE→RESP always.
  - RESP→ISSUE on a grant; otherwise RESP→IDLE.
- Grants are issued only in IDLE or RESP, at most one per cycle. At most one access is outstanding.
- Arbitration: 2-way round-robin using a `last` pointer.
  - When both request, the port not granted last is granted.
  - When one requests, it is granted.
  - `last` updates on every grant. Reset value = LSU, so IFU wins the first tie.
- On grant, the arbiter latches at the clock edge: addr, we (0 for IFU), wdata, requester id, and range error (addr ≥ DEPTH).
- ISSUE, in range:
  - Read: `mem_mode`=1, `mem_write_en`=0.
  - Write: `mem_mode`=0, `mem_write_en`=1, `mem_write_data`=wdata.
  - `mem_addr` = latched addr.
- ISSUE, out of range: no-op drive (`mem_mode`=0, `mem_write_en`=0). The memory is not touched.
- RESP:
  - Assert `rvalid` of the latched requester only. `rdata` = `mem_rdata`; the memory echoes the written word on writes.
  - On range error: `err`=1 and `rdata`=0.
- IDLE drive: `mem_mode`=0, `mem_write_en`=0, `mem_addr` holds its last value. This preserves the memory output register.
- A requester drops `req` the cycle after `gnt`, or keeps it high for a new access. A new request may be issued while a response is pending.

## Timing
- Grant in cycle N; memory access at the edge ending N+1; `rvalid` in N+2 (2-cycle latency). Peak throughput is one access per 2 cycles.
- `gnt` is combinational from `req`, state and `last`. All other outputs are registered or decoded from the state.
- Reset values: state=IDLE, `last`=LSU.
  - All `gnt`/`rvalid`/`err` = 0; `busy`=0.
  - `mem_mode`=0, `mem_write_en`=0, `mem_addr`=0, `mem_write_data`=0.
  - `rdata` outputs = 0.
- Reset mid-operation: the transaction in flight is dropped and no `rvalid` is produced. A write whose ISSUE edge has already occurred remains in memory.
- Simultaneous RESP and new request: `rvalid` for the old access and `gnt` for the new one occur in the same cycle. This applies even when both belong to the same port.
- Address bits above log2(DEPTH) are used only for the range check. They never wrap.

## Structure
- Shared package `veda_mem_pkg` holds:
  - State encoding IDLE/ISSUE/RESP.
  - Requester id constants REQ_IFU/REQ_LSU.
  - MODE_READ=1, MODE_WRITE=0.
  - Default DEPTH.
- One sub-module: `veda_rr_arb2`, a 2-requester round-robin with grant-enable input and `last` pointer. The FSM and datapath latch live in the top.

## Test plan
- IFU reads addr 5 holding 0xDEADBEEF → `ifu_gnt` in cycle N; `mem_mode`=1, `mem_addr`=5 in N+1; `ifu_rvalid`, `ifu_rdata`=0xDEADBEEF in N+2.
- LSU writes 0x12345678 to addr 10, then IFU reads 10 → memory write in ISSUE; `lsu_rdata`=0x12345678; IFU later reads 0x12345678.
- Both requesting continuously from reset → grants alternate IFU, LSU, IFU, … every 2 cycles. No `rvalid` goes to the wrong port.
- LSU writes to addr 300 → `lsu_err`=1, `lsu_rdata`=0, `mem_write_en` never high. Memory word 300 mod 256 (=44) is unchanged.
- Assert `rst` in ISSUE of an IFU read → no `ifu_rvalid`; all outputs at reset values immediately. The first post-reset tie is granted to IFU.
- Back-to-back LSU requests → `lsu_rvalid` and the next `lsu_gnt` coincide in the RESP cycle. `busy` stays high throughout.
